// File: rtl/brick_collision_scanner.sv
`default_nettype none
// ============================================================================
// Module   : brick_collision_scanner
// Brief    : Sweeps the brick memory once per start and reports the lowest-
//            index active brick overlapping the ball, plus the active count.
// Revision : 1.0 - initial release
// ============================================================================
module brick_collision_scanner #(
    parameter int NUM_BRICKS = 40,
    parameter int IDX_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       ballX,
    input  logic [7:0]       ballY,
    input  logic [3:0]       ballW,
    input  logic [3:0]       ballH,
    output logic [IDX_W-1:0] brick_index,
    input  logic [7:0]       brickX,
    input  logic [7:0]       brickY,
    input  logic [3:0]       brickW,
    input  logic [3:0]       brickH,
    input  logic             brickActive,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [IDX_W-1:0] hit_index,
    output logic             hit_xside,
    output logic             clear_req,
    output logic [IDX_W-1:0] clear_index,
    output logic [IDX_W:0]   active_count,
    output logic             all_cleared
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_BRICKS - 1);
    localparam logic [IDX_W:0]   c_cnt_one  = {{IDX_W{1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_ball_x, r_ball_y;
    logic [3:0]       r_ball_w, r_ball_h;
    logic             r_cmp_valid;
    logic [IDX_W-1:0] r_cmp_idx;

    logic             r_acc_hit, w_acc_hit;
    logic [IDX_W-1:0] r_acc_idx, w_acc_idx;
    logic             r_acc_xside, w_acc_xside;
    logic [IDX_W:0]   r_acc_cnt, w_acc_cnt;

    logic             r_hit, r_hit_xside, r_all_cleared;
    logic [IDX_W-1:0] r_hit_index;
    logic [IDX_W:0]   r_active_count;

    // Overlap geometry is carried in 9 bits so right/bottom edges never wrap.
    logic [8:0] w_ball_l, w_ball_t, w_ball_r, w_ball_b;
    logic [8:0] w_brk_l, w_brk_t, w_brk_r, w_brk_b;
    logic [8:0] w_ox, w_oy;
    logic       w_overlap;

    always_comb begin
        w_ball_l  = {1'b0, r_ball_x};
        w_ball_t  = {1'b0, r_ball_y};
        w_ball_r  = {1'b0, r_ball_x} + {5'd0, r_ball_w};
        w_ball_b  = {1'b0, r_ball_y} + {5'd0, r_ball_h};
        w_brk_l   = {1'b0, brickX};
        w_brk_t   = {1'b0, brickY};
        w_brk_r   = {1'b0, brickX} + {5'd0, brickW};
        w_brk_b   = {1'b0, brickY} + {5'd0, brickH};
        w_overlap = brickActive && (w_ball_l < w_brk_r) && (w_brk_l < w_ball_r)
                                && (w_ball_t < w_brk_b) && (w_brk_t < w_ball_b);
        w_ox = ((w_ball_r < w_brk_r) ? w_ball_r : w_brk_r)
             - ((w_ball_l > w_brk_l) ? w_ball_l : w_brk_l);
        w_oy = ((w_ball_b < w_brk_b) ? w_ball_b : w_brk_b)
             - ((w_ball_t > w_brk_t) ? w_ball_t : w_brk_t);
    end

    // Accumulator next-values; also feed the result registers directly so the
    // final compare (registered in DRAIN) lands in the same REPORT update.
    always_comb begin
        w_acc_hit   = r_acc_hit;
        w_acc_idx   = r_acc_idx;
        w_acc_xside = r_acc_xside;
        w_acc_cnt   = r_acc_cnt;
        if (r_cmp_valid) begin
            if (brickActive) begin
                w_acc_cnt = r_acc_cnt + c_cnt_one;
            end
            if (w_overlap && !r_acc_hit) begin
                w_acc_hit   = 1'b1;
                w_acc_idx   = r_cmp_idx;
                w_acc_xside = (w_ox < w_oy);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        brick_index  = '0;
        busy         = (r_state != ST_IDLE);
        done         = (r_state == ST_REPORT);
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_SCAN;
            ST_SCAN: begin
                brick_index = r_idx;
                if (r_idx == c_last_idx) w_state_next = ST_DRAIN;
            end
            ST_DRAIN:  w_state_next = ST_REPORT;
            ST_REPORT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
        clear_req   = done && r_hit;
        clear_index = clear_req ? r_hit_index : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_ball_x       <= '0;
            r_ball_y       <= '0;
            r_ball_w       <= '0;
            r_ball_h       <= '0;
            r_cmp_valid    <= 1'b0;
            r_cmp_idx      <= '0;
            r_acc_hit      <= 1'b0;
            r_acc_idx      <= '0;
            r_acc_xside    <= 1'b0;
            r_acc_cnt      <= '0;
            r_hit          <= 1'b0;
            r_hit_index    <= '0;
            r_hit_xside    <= 1'b0;
            r_active_count <= '0;
            r_all_cleared  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cmp_valid <= (r_state == ST_SCAN);
            r_cmp_idx   <= brick_index;
            if (r_state == ST_IDLE && start) begin
                r_ball_x    <= ballX;
                r_ball_y    <= ballY;
                r_ball_w    <= ballW;
                r_ball_h    <= ballH;
                r_idx       <= '0;
                r_acc_hit   <= 1'b0;
                r_acc_idx   <= '0;
                r_acc_xside <= 1'b0;
                r_acc_cnt   <= '0;
            end else begin
                if (r_state == ST_SCAN) r_idx <= r_idx + 1'b1;
                r_acc_hit   <= w_acc_hit;
                r_acc_idx   <= w_acc_idx;
                r_acc_xside <= w_acc_xside;
                r_acc_cnt   <= w_acc_cnt;
            end
            if (r_state == ST_DRAIN) begin
                r_hit          <= w_acc_hit;
                r_hit_index    <= w_acc_idx;
                r_hit_xside    <= w_acc_xside;
                r_active_count <= w_acc_cnt;
                r_all_cleared  <= (w_acc_cnt == '0);
            end
        end
    end

    assign hit          = r_hit;
    assign hit_index    = r_hit_index;
    assign hit_xside    = r_hit_xside;
    assign active_count = r_active_count;
    assign all_cleared  = r_all_cleared;

endmodule
`default_nettype wire

// File: tb/tb_brick_collision_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_brick_collision_scanner
// Brief    : Directed scoreboard bench for brick_collision_scanner with a
//            synchronous brick memory model and a behavioural overlap model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_brick_collision_scanner;

    localparam int NB = 40;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    ballX, ballY;
    logic [3:0]    ballW, ballH;
    logic [IW-1:0] brick_index;
    logic [7:0]    brickX, brickY;
    logic [3:0]    brickW, brickH;
    logic          brickActive;
    logic          busy, done, hit, hit_xside, clear_req, all_cleared;
    logic [IW-1:0] hit_index, clear_index;
    logic [IW:0]   active_count;

    logic [7:0] m_x [NB];
    logic [7:0] m_y [NB];
    logic [3:0] m_w [NB];
    logic [3:0] m_h [NB];
    logic       m_a [NB];

    typedef struct {
        int hit;
        int idx;
        int xside;
        int cnt;
        int allc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    brick_collision_scanner #(.NUM_BRICKS(NB), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ballX(ballX), .ballY(ballY), .ballW(ballW), .ballH(ballH),
        .brick_index(brick_index),
        .brickX(brickX), .brickY(brickY), .brickW(brickW), .brickH(brickH),
        .brickActive(brickActive),
        .busy(busy), .done(done), .hit(hit), .hit_index(hit_index),
        .hit_xside(hit_xside), .clear_req(clear_req), .clear_index(clear_index),
        .active_count(active_count), .all_cleared(all_cleared)
    );

    // Synchronous-read brick memory: data follows the address by one cycle.
    always @(posedge clk) begin
        brickX      <= m_x[brick_index];
        brickY      <= m_y[brick_index];
        brickW      <= m_w[brick_index];
        brickH      <= m_h[brick_index];
        brickActive <= m_a[brick_index];
    end

    task automatic check_v(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NB; i++) begin
            m_x[i] = '0; m_y[i] = '0; m_w[i] = '0; m_h[i] = '0; m_a[i] = 1'b0;
        end
    endtask

    task automatic set_brick(input int i, input int x, input int y, input int w, input int h);
        m_x[i] = 8'(x); m_y[i] = 8'(y); m_w[i] = 4'(w); m_h[i] = 4'(h); m_a[i] = 1'b1;
    endtask

    function automatic exp_t model(input int bx, input int by, input int bw, input int bh);
        exp_t e;
        int kx, ky, kw, kh, ox, oy;
        e = '{default: 0};
        for (int i = 0; i < NB; i++) begin
            if (m_a[i]) begin
                kx = int'(m_x[i]); ky = int'(m_y[i]); kw = int'(m_w[i]); kh = int'(m_h[i]);
                e.cnt++;
                if (e.hit == 0 && bx < kx + kw && kx < bx + bw && by < ky + kh && ky < by + bh) begin
                    ox = ((bx + bw < kx + kw) ? bx + bw : kx + kw) - ((bx > kx) ? bx : kx);
                    oy = ((by + bh < ky + kh) ? by + bh : ky + kh) - ((by > ky) ? by : ky);
                    e.hit   = 1;
                    e.idx   = i;
                    e.xside = (ox < oy) ? 1 : 0;
                end
            end
        end
        e.allc = (e.cnt == 0) ? 1 : 0;
        return e;
    endfunction

    // Entered at a negedge in IDLE; returns at the negedge one cycle after REPORT.
    task automatic run_scan(input int bx, input int by, input int bw, input int bh,
                            input int repulse_cyc, input int post);
        exp_t e;
        int cyc, clr, extra;
        sb.push_back(model(bx, by, bw, bh));
        ballX = 8'(bx); ballY = 8'(by); ballW = 4'(bw); ballH = 4'(bh);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ballX = 8'd0; ballY = 8'd0; ballW = 4'd15; ballH = 4'd15;
        cyc = 1;
        clr = 0;
        while (cyc < 60) begin
            if (done) break;
            if (cyc <= NB) check_v("brick_index", brick_index, cyc - 1);
            check_v("busy_during_scan", busy, 1);
            if (clear_req) clr++;
            start = (cyc == repulse_cyc);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_v("done_latency", done ? cyc : 0, NB + 2);
        if (clear_req) clr++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_v("hit", hit, e.hit);
            if (e.hit != 0) begin
                check_v("hit_index", hit_index, e.idx);
                check_v("hit_xside", hit_xside, e.xside);
                check_v("clear_index", clear_index, e.idx);
            end
            check_v("active_count", active_count, e.cnt);
            check_v("all_cleared", all_cleared, e.allc);
            check_v("clear_req_pulses", clr, e.hit);
            check_v("busy_in_report", busy, 1);
            @(negedge clk);
            check_v("done_after_report", done, 0);
            check_v("busy_after_report", busy, 0);
            check_v("clear_req_after_report", clear_req, 0);
            check_v("brick_index_idle", brick_index, 0);
            extra = 0;
            for (int i = 0; i < post; i++) begin
                if (done || clear_req) extra++;
                @(negedge clk);
            end
            check_v("no_extra_done", extra, 0);
            check_v("hit_held", hit, e.hit);
            check_v("count_held", active_count, e.cnt);
        end else begin
            check_v("scoreboard_underflow", 1, 0);
        end
    endtask

    initial begin
        int spurious;
        reset = 1'b1; start = 1'b0;
        ballX = '0; ballY = '0; ballW = '0; ballH = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        // Reset state, including start held high to show reset wins.
        start = 1'b1;
        @(negedge clk);
        check_v("rst_busy", busy, 0);
        check_v("rst_done", done, 0);
        check_v("rst_hit", hit, 0);
        check_v("rst_hit_index", hit_index, 0);
        check_v("rst_clear_req", clear_req, 0);
        check_v("rst_active_count", active_count, 0);
        check_v("rst_all_cleared", all_cleared, 0);
        check_v("rst_brick_index", brick_index, 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Single hit at brick 5
        clear_mem();
        set_brick(5, 12, 12, 8, 4);
        run_scan(10, 10, 4, 4, 0, 3);

        // Two overlaps: lowest index wins, non-overlapping active brick counted
        clear_mem();
        set_brick(3, 1, 1, 2, 2);
        set_brick(7, 0, 0, 5, 5);
        set_brick(10, 100, 100, 4, 4);
        run_scan(0, 0, 4, 4, 0, 5);

        // Exact edge contact is not a hit
        clear_mem();
        set_brick(0, 0, 0, 8, 4);
        run_scan(8, 0, 4, 4, 0, 3);

        // Nothing active
        clear_mem();
        run_scan(20, 20, 4, 4, 0, 3);

        // Far corner, last index, sums beyond 255; back-to-back start follows
        set_brick(39, 248, 248, 8, 8);
        run_scan(250, 250, 15, 15, 0, 0);
        clear_mem();
        set_brick(0, 8, 12, 8, 8);
        run_scan(10, 10, 2, 8, 0, 2);

        // Reset during a scan that has already produced results
        clear_mem();
        set_brick(2, 12, 8, 8, 8);
        ballX = 8'd10; ballY = 8'd10; ballW = 4'd8; ballH = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_v("mid_rst_busy", busy, 0);
        check_v("mid_rst_done", done, 0);
        check_v("mid_rst_hit", hit, 0);
        check_v("mid_rst_hit_index", hit_index, 0);
        check_v("mid_rst_hit_xside", hit_xside, 0);
        check_v("mid_rst_clear_req", clear_req, 0);
        check_v("mid_rst_clear_index", clear_index, 0);
        check_v("mid_rst_active_count", active_count, 0);
        check_v("mid_rst_all_cleared", all_cleared, 0);
        check_v("mid_rst_brick_index", brick_index, 0);
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || clear_req || busy) spurious++;
        end
        check_v("mid_rst_no_done", spurious, 0);
        run_scan(10, 10, 8, 2, 0, 2);

        // start re-pulsed mid-scan is ignored; ox=6, oy=2 gives vertical reflect
        clear_mem();
        set_brick(0, 12, 8, 8, 8);
        set_brick(20, 200, 200, 4, 4);
        run_scan(10, 10, 8, 2, 10, 45);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/brick_collision_scanner.md
BRICK_COLLISION_SCANNER -- requirements
Module: brick_collision_scanner

Interface
REQ-001 Parameter: NUM_BRICKS, default 40, number of brick slots scanned, indices 0..NUM_BRICKS-1.
REQ-002 Parameter: IDX_W, default 6, index width; SHALL satisfy 2^IDX_W >= NUM_BRICKS.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to scan all bricks against the current ball box.
REQ-007 ballX, ballY  in  8 each  ball box top-left corner.
REQ-008 ballW, ballH  in  4 each  ball box width and height.
REQ-009 brick_index  out  IDX_W  read address to the brick memory.
REQ-010 brickX, brickY  in  8 each  brick top-left corner from memory, valid one cycle after brick_index.
REQ-011 brickW, brickH  in  4 each  brick width and height from memory.
REQ-012 brickActive  in  1  brick present flag from memory.
REQ-013 busy  out  1  scan in progress.
REQ-014 done  out  1  single-cycle pulse marking results valid.
REQ-015 hit  out  1  at least one active brick overlapped the ball in the last scan.
REQ-016 hit_index  out  IDX_W  lowest overlapping active brick index.
REQ-017 hit_xside  out  1  1 = reflect ball horizontally, 0 = vertically.
REQ-018 clear_req, clear_index  out  1, IDX_W  single-cycle request to deactivate a brick.
REQ-019 active_count  out  IDX_W+1  active bricks counted in the last scan, including any hit brick.
REQ-020 all_cleared  out  1  active_count == 0 after the last scan.

Function
REQ-021 FSM states: IDLE, SCAN, DRAIN, REPORT.
- IDLE -> SCAN when start = 1.
- SCAN -> DRAIN after index NUM_BRICKS-1 is issued.
- DRAIN -> REPORT after one cycle.
- REPORT -> IDLE after one cycle.
REQ-022 Cycle 0 = start sampled in IDLE; ballX/Y/W/H are latched on that edge and are ignored for the rest of the scan.
REQ-023 Address sequence: cycles 1..NUM_BRICKS drive brick_index = 0..NUM_BRICKS-1, incrementing by 1 with no gaps.
REQ-024 Compare stage:
- Memory data presented in cycle k (k = 2..NUM_BRICKS+1) belongs to index k-2.
- Each compare is evaluated and registered at the end of cycle k.
REQ-025 Overlap test, 9-bit unsigned sums (no 8-bit wrap), strict inequalities; edge-touching is not a hit:
- ballX < brickX+brickW
- brickX < ballX+ballW
- ballY < brickY+brickH
- brickY < ballY+ballH
REQ-026 Bricks with brickActive = 0 are never hits and are not counted.
REQ-027 First-hit capture: only the lowest-index hit is captured; later hits in the same scan are ignored.
REQ-028 hit_xside, 9-bit unsigned:
- ox = min(ballX+ballW, brickX+brickW) - max(ballX, brickX)
- oy = same form on the Y axis
- hit_xside = (ox < oy); a tie gives 0.
REQ-029 REPORT, cycle NUM_BRICKS+2:
- done = 1 for exactly one cycle; hit, hit_index, hit_xside, active_count and all_cleared update on the same edge.
- If hit = 1: clear_req = 1 for that cycle with clear_index = hit_index.
- If hit = 0: clear_req stays 0.
REQ-030 busy = 1 in cycles 1..NUM_BRICKS+2, 0 otherwise.
REQ-031 start while busy is ignored; it is neither queued nor restarts the scan.
REQ-032 Result outputs hold their values until the next REPORT.
REQ-033 brick_index = 0 whenever not in SCAN.
REQ-034 Total scan latency from start to done = NUM_BRICKS+2 cycles; back-to-back start is accepted in the cycle after REPORT.

Reset
REQ-035 On reset = 1 at a clock edge:
- state = IDLE.
- brick_index, busy, done, hit, hit_index, hit_xside, clear_req, clear_index, active_count = 0.
- all_cleared = 0.
REQ-036 Reset mid-scan aborts it: no done pulse, no clear_req for that scan, and any partial results are discarded.
REQ-037 reset has priority over start in the same cycle.

Verification
REQ-038 Ball (10,10,4,4); only brick 5 active at (12,12,8,4); start -> done at cycle 42, hit = 1, hit_index = 5, clear_req with clear_index = 5, active_count = 1.
REQ-039 Ball (0,0,4,4); bricks 3 and 7 both overlapping and active -> hit_index = 3, exactly one clear_req pulse.
REQ-040 Ball touching a brick edge exactly, ball (8,0,4,4) vs brick (0,0,8,4) -> hit = 0, clear_req never asserted.
REQ-041 All bricks inactive -> hit = 0, active_count = 0, all_cleared = 1; ball (250,250,15,15) near brick (248,248,8,8) -> hit = 1 (9-bit sums, no wrap).
REQ-042 Reset asserted at cycle 20 of a scan -> all outputs 0 next cycle, no done/clear_req; a subsequent start completes normally.
REQ-043 start re-pulsed at cycle 10 -> ignored, single done at cycle 42; ball (10,10,8,2) vs brick (12,8,8,8): ox = 6, oy = 2 -> hit_xside = 0.
